// File: rtl/flopenr_pipe.sv
// flopenr_pipe: elastic chain of DEPTH enable-flops with a valid bit per stage
// and valid/ready handshakes at both ends. Stage enables ripple back from the
// output so empty stages always load (bubbles collapse) and a stall never drops
// or duplicates a word. A synchronous flush discards everything in flight.
module flopenr_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] en;
    logic             accept;
    logic             deliver;

    // A stage may load when it is empty or when the stage after it can move on.
    always_comb begin : enable_chain
        logic ripple;
        en     = '0;
        ripple = !valid_q[DEPTH-1] | out_ready;
        en[DEPTH-1] = ripple;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            ripple = !valid_q[i] | ripple;
            en[i]  = ripple;
        end
    end

    assign in_ready  = en[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    // Occupancy tracks accepts minus deliveries; both together cancel out.
    always_comb begin
        count_d = count_q;
        if (accept && !deliver) begin
            count_d = count_q + CW'(1);
        end else if (deliver && !accept) begin
            count_d = count_q - CW'(1);
        end
    end

    // Advance enabled stages; data only moves with a valid word to avoid toggling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (en[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (en[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_flopenr_pipe.sv
// tb_flopenr_pipe: scoreboard bench for flopenr_pipe with WIDTH=8, DEPTH=3,
// RESET_VAL=8'h33. A negedge monitor pushes accepted words and pops/compares
// delivered ones; each test task adds its own latency/handshake checks.
module tb_flopenr_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam logic [WIDTH-1:0] RST = 8'h33;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int checks;
    int failures;
    int delivered;
    logic [WIDTH-1:0] sb [$];

    flopenr_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard monitor: handshakes are stable at the falling edge
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp;
        if (!reset) begin
            checks++;
            if (count !== sb.size()) begin
                failures++;
                $display("[TB] FAIL sb_count: count=%0d required=%0d", count, sb.size());
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    delivered++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL sb_extra: delivered %h with no word outstanding", out_data);
                    end else begin
                        exp = sb.pop_front();
                        if (out_data !== exp) begin
                            failures++;
                            $display("[TB] FAIL sb_data: out_data=%h required=%h", out_data, exp);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(in_data);
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            stepCycle();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic fillThree(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] w [3];
        w[0] = a; w[1] = b; w[2] = c;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            stepCycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) stepCycle();
        reset = 1'b0;
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready: got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
        if (out_data !== RST) begin failures++; $display("[TB] FAIL rst_out_data: got %h required %h", out_data, RST); end
        if (count !== 2'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d required 0", count); end
        stepCycle();
        fillThree(8'hAA, 8'hBB, 8'hCC);
        #1;
        checks += 2;
        if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
            failures++;
            $display("[TB] FAIL pre_rst_out: valid=%b data=%h required 1/aa", out_valid, out_data);
        end
        if (count !== 2'd3) begin failures++; $display("[TB] FAIL pre_rst_count: got %0d required 3", count); end
        reset = 1'b1;
        sb.delete();
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_valid: got %b required 0", out_valid); end
        if (out_data !== RST) begin failures++; $display("[TB] FAIL async_rst_data: got %h required %h", out_data, RST); end
        if (count !== 2'd0) begin failures++; $display("[TB] FAIL async_rst_count: got %0d required 0", count); end
        stepCycle();
        reset = 1'b0;
        stepCycle();
    endtask

    task automatic test_streaming();
        int d0;
        d0 = delivered;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(k + 1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready_%0d: got %b required 1", k, in_ready); end
            stepCycle();
            checks += 2;
            if (out_valid !== (k >= 2)) begin
                failures++;
                $display("[TB] FAIL stream_valid_%0d: got %b required %b", k, out_valid, (k >= 2));
            end
            if (count !== ((k < 2) ? k + 1 : 3)) begin
                failures++;
                $display("[TB] FAIL stream_count_%0d: got %0d required %0d", k, count, (k < 2) ? k + 1 : 3);
            end
            if (k >= 2) begin
                checks++;
                if (out_data !== WIDTH'(k - 1)) begin
                    failures++;
                    $display("[TB] FAIL stream_data_%0d: got %h required %h", k, out_data, WIDTH'(k - 1));
                end
            end
        end
        drain("stream");
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_valid: got %b required 0", out_valid); end
        if (out_data !== 8'h0A) begin failures++; $display("[TB] FAIL empty_hold_data: got %h required 0a", out_data); end
        if (delivered - d0 !== 10) begin failures++; $display("[TB] FAIL stream_total: got %0d required 10", delivered - d0); end
    endtask

    task automatic test_back_pressure();
        logic [WIDTH-1:0] w [4];
        int idx;
        int d0;
        w[0] = 8'hFF; w[1] = 8'hA5; w[2] = 8'h5A; w[3] = 8'hC3;
        d0 = delivered;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = w[idx];
            #1;
            checks++;
            if (in_ready !== (c < 3)) begin
                failures++;
                $display("[TB] FAIL bp_ready_%0d: got %b required %b", c, in_ready, (c < 3));
            end
            stepCycle();
            if (c < 3) idx++;
            checks++;
            if (count !== ((c < 3) ? c + 1 : 3)) begin
                failures++;
                $display("[TB] FAIL bp_count_%0d: got %0d required %0d", c, count, (c < 3) ? c + 1 : 3);
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL bp_head: valid=%b data=%h required 1/ff", out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_full_ready: got %b required 1", in_ready); end
        stepCycle();
        drain("bp");
        checks++;
        if (delivered - d0 !== 4) begin failures++; $display("[TB] FAIL bp_total: got %0d required 4", delivered - d0); end
    endtask

    task automatic test_bubbles();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        stepCycle();
        in_valid = 1'b0;
        repeat (2) stepCycle();
        in_valid = 1'b1; in_data = 8'h22;
        stepCycle();
        in_valid = 1'b0;
        stepCycle();
        checks += 3;
        if (count !== 2'd2) begin failures++; $display("[TB] FAIL bub_count: got %0d required 2", count); end
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            failures++;
            $display("[TB] FAIL bub_head: valid=%b data=%h required 1/11", out_valid, out_data);
        end
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bub_ready: got %b required 1", in_ready); end
        out_ready = 1'b1;
        stepCycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            failures++;
            $display("[TB] FAIL bub_collapsed: valid=%b data=%h required 1/22", out_valid, out_data);
        end
        drain("bub");
    endtask

    task automatic test_flush();
        int d0;
        fillThree(8'h81, 8'h82, 8'h83);
        d0 = delivered;
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        #1;
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %b required 0", out_valid); end
        stepCycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks += 3;
        if (count !== 2'd0) begin failures++; $display("[TB] FAIL flush_count: got %0d required 0", count); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_after_valid: got %b required 0", out_valid); end
        if (out_data !== 8'h81) begin failures++; $display("[TB] FAIL flush_hold_data: got %h required 81", out_data); end
        repeat (3) stepCycle();
        checks++;
        if (delivered !== d0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_no_deliver: delivered=%0d required %0d", delivered - d0, 0);
        end
    endtask

    task automatic test_back_to_back();
        fillThree(8'h61, 8'h62, 8'h63);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %b required 1", in_ready); end
        stepCycle();
        in_valid = 1'b0;
        checks += 2;
        if (count !== 2'd3) begin failures++; $display("[TB] FAIL b2b_count: got %0d required 3", count); end
        if (out_data !== 8'h62) begin failures++; $display("[TB] FAIL b2b_next: got %h required 62", out_data); end
        repeat (2) stepCycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            failures++;
            $display("[TB] FAIL b2b_77: valid=%b data=%h required 1/77", out_valid, out_data);
        end
        drain("b2b");
    endtask

    // Run every scenario in order, then report
    initial begin
        checks = 0;
        failures = 0;
        delivered = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubbles();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
